tsi_arbiter: RTL and testbench

// - Shares one TSI target port (SimTSI-style 32-bit valid/ready streams) between NUM_REQ host-side TSI masters.
// - Grants one requester per complete TSI transaction. Forwards its command stream to the target.
// - Routes read responses back to the same requester only.
// - Sits between the host bridges / debug masters and the single TSI link into the SoC serial adapter.

---
 rtl/tsi_arbiter.sv | 109 ++++++++++
 tb/tb_tsi_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/tsi_arbiter.sv
// tsi_arbiter: round-robin sharing of one TSI target port among NUM_REQ TSI masters, one whole packet per grant.
// Ports:
//   clock, reset_n                  clock and asynchronous active-low reset
//   req_out_valid/ready/bits        per-requester command/data streams (requester i uses bits [32*i+:32])
//   req_in_valid/ready/bits         per-requester response streams (bits replicated to every slice)
//   tsi_out_valid/ready/bits        command/data stream to the target
//   tsi_in_valid/ready/bits         response stream from the target
//   busy                            high whenever a packet is in flight
//   grant_id                        current or most recent granted requester
//   error                           sticky protocol error (bad CMD or non-zero LEN_HI)
module tsi_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int GNT_W   = $clog2(NUM_REQ)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [NUM_REQ-1:0]    req_out_valid,
    output logic [NUM_REQ-1:0]    req_out_ready,
    input  logic [32*NUM_REQ-1:0] req_out_bits,
    output logic [NUM_REQ-1:0]    req_in_valid,
    input  logic [NUM_REQ-1:0]    req_in_ready,
    output logic [32*NUM_REQ-1:0] req_in_bits,
    output logic                  tsi_out_valid,
    input  logic                  tsi_out_ready,
    output logic [31:0]           tsi_out_bits,
    input  logic                  tsi_in_valid,
    output logic                  tsi_in_ready,
    input  logic [31:0]           tsi_in_bits,
    output logic                  busy,
    output logic [GNT_W-1:0]      grant_id,
    output logic                  error
);
    typedef enum logic [1:0] {IDLE, HDR, WDATA, RDATA} state_t;
    state_t state, state_d;
    logic [GNT_W-1:0] rr_ptr, pick, idx, next_ptr;
    logic [32:0] cnt;
    logic [31:0] cmd_q, len_q;
    logic any_req, fwd, rdat, out_hs, in_hs, last, hdr_done, cmd_ok;

    assign any_req       = |req_out_valid;
    assign fwd           = state == HDR || state == WDATA;
    assign rdat          = state == RDATA;
    assign tsi_out_valid = fwd && req_out_valid[grant_id];
    assign tsi_out_bits  = req_out_bits[32*grant_id +: 32];
    assign tsi_in_ready  = rdat && req_in_ready[grant_id];
    assign req_in_bits   = {NUM_REQ{tsi_in_bits}};
    assign busy          = state != IDLE;
    assign out_hs        = tsi_out_valid && tsi_out_ready;
    assign in_hs         = tsi_in_valid && tsi_in_ready;
    // 33-bit compare so LEN_LO = 0xFFFFFFFF means 2^32 words without wrapping
    assign last          = cnt == {1'b0, len_q};
    assign hdr_done      = state == HDR && out_hs && cnt == 33'd4;
    assign cmd_ok        = cmd_q == 32'd0 || cmd_q == 32'd1;
    assign next_ptr      = (grant_id == GNT_W'(NUM_REQ - 1)) ? '0 : grant_id + GNT_W'(1);

    always_comb begin
        req_out_ready           = '0;
        req_in_valid            = '0;
        req_out_ready[grant_id] = fwd && tsi_out_ready;
        req_in_valid[grant_id]  = rdat && tsi_in_valid;
    end

    // Scan from the farthest candidate back to rr_ptr so the nearest valid one wins.
    always_comb begin
        pick = rr_ptr;
        idx  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = GNT_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (req_out_valid[idx]) pick = idx;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = any_req ? HDR : IDLE;
            HDR:     state_d = !hdr_done ? HDR : cmd_q == 32'd1 ? WDATA : cmd_q == 32'd0 ? RDATA : IDLE;
            WDATA:   state_d = (out_hs && last) ? IDLE : WDATA;
            RDATA:   state_d = (in_hs && last) ? IDLE : RDATA;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            cnt      <= '0;
            cmd_q    <= '0;
            len_q    <= '0;
            error    <= 1'b0;
        end else begin
            state <= state_d;
            if (state == IDLE && any_req) begin
                grant_id <= pick;
                cnt      <= '0;
            end else if (hdr_done) begin
                cnt <= '0;
            end else if (out_hs || in_hs) begin
                cnt <= cnt + 33'd1;
            end
            if (state == HDR && out_hs && cnt == 33'd0) cmd_q <= tsi_out_bits;
            if (state == HDR && out_hs && cnt == 33'd3) len_q <= tsi_out_bits;
            if (hdr_done && (tsi_out_bits != 32'd0 || !cmd_ok)) error <= 1'b1;
            if (((state == WDATA && out_hs) || (rdat && in_hs)) && last) rr_ptr <= next_ptr;
        end
    end
endmodule

// File: tb/tb_tsi_arbiter.sv
// tb_tsi_arbiter: scoreboard bench for tsi_arbiter with two requesters.
module tb_tsi_arbiter;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n;
    logic        v0, v1;
    logic [31:0] d0, d1;
    logic [1:0]  req_out_ready, req_in_valid;
    logic [1:0]  req_in_ready = 2'b11;
    logic [63:0] req_in_bits;
    logic        tsi_out_valid, tsi_out_ready, tsi_in_valid, tsi_in_ready, busy, error;
    logic [31:0] tsi_out_bits, tsi_in_bits;
    logic [0:0]  grant_id;

    typedef struct {logic [31:0] d; int r;} exp_t;
    logic [31:0] q0[$], q1[$], rsp[$];
    exp_t        exp_out[$], exp_rsp[$];
    int          vectors = 0, miscompares = 0, out_words = 0;
    logic        rnd = 1'b0;

    tsi_arbiter #(.NUM_REQ(2), .GNT_W(1)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_out_valid({v1, v0}), .req_out_ready(req_out_ready), .req_out_bits({d1, d0}),
        .req_in_valid(req_in_valid), .req_in_ready(req_in_ready), .req_in_bits(req_in_bits),
        .tsi_out_valid(tsi_out_valid), .tsi_out_ready(tsi_out_ready), .tsi_out_bits(tsi_out_bits),
        .tsi_in_valid(tsi_in_valid), .tsi_in_ready(tsi_in_ready), .tsi_in_bits(tsi_in_bits),
        .busy(busy), .grant_id(grant_id), .error(error)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_pkt(input int r, input logic [31:0] cmd, addr, len_lo, len_hi, base);
        logic [31:0] w[$];
        w = '{cmd, addr, 32'd0, len_lo, len_hi};
        if (cmd == 32'd1)
            for (int k = 0; k <= int'(len_lo); k++) w.push_back(base + 32'(k));
        foreach (w[i]) begin
            if (r == 0) q0.push_back(w[i]);
            else q1.push_back(w[i]);
            exp_out.push_back('{w[i], r});
        end
    endtask

    task automatic push_rsp(input int r, input logic [31:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            rsp.push_back(base + 32'(k));
            exp_rsp.push_back('{base + 32'(k), r});
        end
    endtask

    task automatic flush();
        q0.delete();
        q1.delete();
        rsp.delete();
        exp_out.delete();
        exp_rsp.delete();
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((q0.size() + q1.size() + rsp.size()) != 0 && n < 3000) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_busy"}, busy, 0);
        check({tag, "_left"}, 64'(q0.size() + q1.size() + rsp.size() + exp_out.size() + exp_rsp.size()), 0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        flush();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Bus model: requesters and target driven #1 after posedge, DUT sampled on negedge.
    initial begin
        logic h0, h1, hi;
        exp_t e;
        v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0;
        tsi_out_ready = 1'b1; tsi_in_valid = 1'b0; tsi_in_bits = '0;
        forever begin
            @(negedge clock);
            h0 = v0 && req_out_ready[0];
            h1 = v1 && req_out_ready[1];
            hi = tsi_in_valid && tsi_in_ready;
            if (tsi_out_valid && tsi_out_ready) begin
                out_words++;
                if (exp_out.size() != 0) begin
                    e = exp_out.pop_front();
                    check("out_bits", tsi_out_bits, e.d);
                    check("out_gnt", grant_id, e.r);
                    check("out_rdy", req_out_ready, 64'(1) << e.r);
                end else check("out_unexp", tsi_out_valid, 0);
            end
            if (hi) begin
                if (exp_rsp.size() != 0) begin
                    e = exp_rsp.pop_front();
                    check("rsp_vld", req_in_valid, 64'(1) << e.r);
                    check("rsp_bits", req_in_bits[32*e.r +: 32], e.d);
                end else check("rsp_unexp", tsi_in_ready, 0);
            end
            @(posedge clock);
            #1;
            if (h0 && q0.size() != 0) void'(q0.pop_front());
            if (h1 && q1.size() != 0) void'(q1.pop_front());
            if (hi && rsp.size() != 0) void'(rsp.pop_front());
            v0 = q0.size() != 0;
            d0 = v0 ? q0[0] : 32'd0;
            v1 = q1.size() != 0;
            d1 = v1 ? q1[0] : 32'd0;
            tsi_out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tsi_in_valid = rsp.size() != 0;
            tsi_in_bits = tsi_in_valid ? rsp[0] : 32'd0;
        end
    end

    initial begin
        int n0, n;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_err", error, 0);
        check("rst_gnt", grant_id, 0);
        check("rst_tov", tsi_out_valid, 0);
        check("rst_tir", tsi_in_ready, 0);
        check("rst_ror", req_out_ready, 0);
        check("rst_riv", req_in_valid, 0);
        reset_n = 1'b1;

        push_pkt(0, 1, 32'h1000, 0, 0, 32'hD0);
        wait_idle("wr0");
        check("wr0_err", error, 0);

        push_pkt(1, 0, 32'h2000, 3, 0, 0);
        push_rsp(1, 32'hA0, 4);
        wait_idle("rd1");
        check("rd1_gnt", grant_id, 1);

        push_pkt(0, 1, 32'h3000, 1, 0, 32'h300);
        push_pkt(1, 1, 32'h4000, 1, 0, 32'h400);
        push_pkt(0, 1, 32'h3100, 1, 0, 32'h310);
        push_pkt(1, 1, 32'h4100, 1, 0, 32'h410);
        wait_idle("rr");

        rnd = 1'b1;
        n0 = out_words;
        push_pkt(0, 1, 32'h5000, 7, 0, 32'h500);
        wait_idle("bp");
        check("bp_words", 64'(out_words - n0), 13);
        rnd = 1'b0;

        push_pkt(0, 2, 32'h6000, 0, 0, 0);
        wait_idle("cmd2");
        check("cmd2_err", error, 1);
        do_reset();
        check("rst2_err", error, 0);

        push_pkt(1, 1, 32'h7000, 1, 1, 32'h700);
        wait_idle("lenhi");
        check("lenhi_err", error, 1);
        do_reset();

        rnd = 1'b1;
        push_pkt(0, 1, 32'h8000, 7, 0, 32'h800);
        n = 0;
        while (q0.size() > 6 && n < 500) begin
            @(negedge clock);
            n++;
        end
        check("mw_busy_pre", busy, 1);
        #2 reset_n = 1'b0;
        #1;
        check("mw_tov", tsi_out_valid, 0);
        check("mw_ror", req_out_ready, 0);
        check("mw_busy", busy, 0);
        flush();
        rnd = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;

        push_pkt(1, 0, 32'h9000, 3, 0, 0);
        push_rsp(1, 32'hB0, 4);
        n = 0;
        while (rsp.size() > 2 && n < 500) begin
            @(negedge clock);
            n++;
        end
        check("mr_busy_pre", busy, 1);
        check("mr_gnt_pre", grant_id, 1);
        #2 reset_n = 1'b0;
        #1;
        check("mr_tir", tsi_in_ready, 0);
        check("mr_riv", req_in_valid, 0);
        check("mr_busy", busy, 0);
        check("mr_gnt", grant_id, 0);
        flush();
        @(negedge clock);
        reset_n = 1'b1;

        push_pkt(1, 1, 32'hA000, 0, 0, 32'hA00);
        wait_idle("recover");
        check("recover_err", error, 0);
        check("recover_gnt", grant_id, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
